// File: rtl/xt_unit_mp_if.sv
// xt_unit_mp_if: packet, memory request/response and response-packet buses
interface xt_unit_mp_if #(
  parameter int AW  = 19,
  parameter int DW  = 32,
  parameter int IDW = 3,
  parameter int NI  = 2
);
  localparam int SW = DW / 8;
  localparam int PW = 2*IDW + AW + 1 + SW + DW;
  logic [NI-1:0]         tpkt_vld;
  logic [NI*PW-1:0]      tpkt_dat;
  logic [NI-1:0]         tpkt_gnt;
  logic                  req_vld;
  logic                  req_gnt;
  logic                  req_wr;
  logic [AW-1:0]         req_adr;
  logic [SW-1:0]         req_strb;
  logic [DW-1:0]         req_dat;
  logic                  rsp_vld;
  logic                  rsp_gnt;
  logic [DW-1:0]         rsp_dat;
  logic                  rpkt_vld;
  logic                  rpkt_gnt;
  logic [2*IDW+DW-1:0]   rpkt_dat;
  modport slave (
    input  tpkt_vld, tpkt_dat, req_gnt, rsp_vld, rsp_dat, rpkt_gnt,
    output tpkt_gnt, req_vld, req_wr, req_adr, req_strb, req_dat, rsp_gnt, rpkt_vld, rpkt_dat
  );
  modport master (
    output tpkt_vld, tpkt_dat, req_gnt, rsp_vld, rsp_dat, rpkt_gnt,
    input  tpkt_gnt, req_vld, req_wr, req_adr, req_strb, req_dat, rsp_gnt, rpkt_vld, rpkt_dat
  );
endinterface

// File: rtl/xt_unit_mp.sv
// xt_unit_mp: round-robin packet-to-memory bridge with in-order response packets
module xt_unit_mp #(
  parameter int AW              = 19,
  parameter int DW              = 32,
  parameter int IDW             = 3,
  parameter int ID              = 0,
  parameter int NI              = 2,
  parameter int REQ_DEPTH       = 2,
  parameter int OUTSTANDING_NUM = 2,
  parameter int WR_RSP          = 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  xt_unit_mp_if.slave                           bus,
  output logic [$clog2(OUTSTANDING_NUM+1)-1:0]  outst_cnt,
  output logic                                  err
);
  localparam int SW = DW / 8;
  localparam int PW = 2*IDW + AW + 1 + SW + DW;
  localparam int CW = $clog2(OUTSTANDING_NUM + 1);
  localparam int EW = PW - IDW;
  localparam int TW = IDW + 1;
  localparam int AP = NI > 1 ? $clog2(NI) : 1;
  localparam int RP = REQ_DEPTH > 1 ? $clog2(REQ_DEPTH) : 1;
  localparam int RC = $clog2(REQ_DEPTH + 1);
  localparam int TP = OUTSTANDING_NUM > 1 ? $clog2(OUTSTANDING_NUM) : 1;

  logic [AP-1:0]       ptr_q, ptr_d, win, cand;
  logic                win_vld, push, issue, rsp_acc, tag_pop, load;
  logic [EW-1:0]       ent [NI];
  logic [EW-1:0]       rmem_q [REQ_DEPTH];
  logic [EW-1:0]       rmem_d [REQ_DEPTH];
  logic [RP-1:0]       rwp_q, rwp_d, rrp_q, rrp_d;
  logic [RC-1:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]       tmem_q [OUTSTANDING_NUM];
  logic [TW-1:0]       tmem_d [OUTSTANDING_NUM];
  logic [TP-1:0]       twp_q, twp_d, trp_q, trp_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rv_q, rv_d, err_q, err_d;
  logic [2*IDW+DW-1:0] rd_q, rd_d;
  logic [EW-1:0]       head;
  logic [TW-1:0]       tag;

  // strip TGTID from every channel so the FIFO holds {INITID, ADR, WE, STRB, DATA}
  always_comb begin
    for (int i = 0; i < NI; i++) ent[i] = {bus.tpkt_dat[i*PW+PW-IDW +: IDW], bus.tpkt_dat[i*PW +: PW-2*IDW]};
  end

  // round-robin search: the lowest offset from the pointer with a valid channel wins
  always_comb begin
    win = ptr_q;
    win_vld = 1'b0;
    cand = '0;
    for (int k = NI - 1; k >= 0; k--) begin
      cand = AP'((int'(ptr_q) + k) % NI);
      if (bus.tpkt_vld[cand]) begin
        win = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign push         = rstn & win_vld & (rcnt_q != RC'(REQ_DEPTH));
  assign bus.tpkt_gnt = push ? NI'(1) << win : '0;
  assign head         = rmem_q[rrp_q];
  assign bus.req_vld  = rstn & (rcnt_q != '0) & (cnt_q < CW'(OUTSTANDING_NUM));
  assign bus.req_dat  = head[DW-1:0];
  assign bus.req_strb = head[DW +: SW];
  assign bus.req_wr   = head[DW+SW];
  assign bus.req_adr  = head[DW+SW+1 +: AW];
  assign issue        = bus.req_vld & bus.req_gnt;
  assign bus.rsp_gnt  = ~rstn | ~rv_q | bus.rpkt_gnt;
  assign rsp_acc      = bus.rsp_vld & bus.rsp_gnt;
  assign tag          = tmem_q[trp_q];
  assign tag_pop      = rsp_acc & (cnt_q != '0);
  assign load         = tag_pop & ((WR_RSP != 0) | ~tag[0]);
  assign bus.rpkt_vld = rv_q;
  assign bus.rpkt_dat = rd_q;
  assign outst_cnt    = cnt_q;
  assign err          = err_q;

  // request FIFO; fullness is judged before any same-cycle pop
  always_comb begin
    rmem_d = rmem_q;
    if (push) rmem_d[rwp_q] = ent[win];
    rwp_d  = push ? (rwp_q == RP'(REQ_DEPTH-1) ? '0 : rwp_q + 1'b1) : rwp_q;
    rrp_d  = issue ? (rrp_q == RP'(REQ_DEPTH-1) ? '0 : rrp_q + 1'b1) : rrp_q;
    rcnt_d = rcnt_q + RC'(push) - RC'(issue);
    ptr_d  = push ? (win == AP'(NI-1) ? '0 : win + 1'b1) : ptr_q;
  end

  // tag FIFO of {INITID, WE}; its occupancy is the outstanding count
  always_comb begin
    tmem_d = tmem_q;
    if (issue) tmem_d[twp_q] = {head[EW-1 -: IDW], head[DW+SW]};
    twp_d = issue ? (twp_q == TP'(OUTSTANDING_NUM-1) ? '0 : twp_q + 1'b1) : twp_q;
    trp_d = tag_pop ? (trp_q == TP'(OUTSTANDING_NUM-1) ? '0 : trp_q + 1'b1) : trp_q;
    cnt_d = cnt_q + CW'(issue) - CW'(tag_pop);
  end

  // response packet register and sticky error for orphan responses
  always_comb begin
    rv_d  = load | (rv_q & ~bus.rpkt_gnt);
    rd_d  = load ? {IDW'(ID), tag[TW-1:1], bus.rsp_dat} : rd_q;
    err_d = err_q | (rsp_acc & (cnt_q == '0));
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q  <= '0;
      rmem_q <= '{default: '0};
      rwp_q  <= '0;
      rrp_q  <= '0;
      rcnt_q <= '0;
      tmem_q <= '{default: '0};
      twp_q  <= '0;
      trp_q  <= '0;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rmem_q <= rmem_d;
      rwp_q  <= rwp_d;
      rrp_q  <= rrp_d;
      rcnt_q <= rcnt_d;
      tmem_q <= tmem_d;
      twp_q  <= twp_d;
      trp_q  <= trp_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: tb/tb_xt_unit_mp.sv
// tb_xt_unit_mp: vector table, directed corner sequences and a queue-based random model
module tb_xt_unit_mp;
  localparam int AW = 19, DW = 32, IDW = 3, NI = 2, SW = DW/8;
  localparam int PW = 2*IDW + AW + 1 + SW + DW;
  localparam int TDW = NI*PW;
  localparam int RD = 2, ON = 2;

  typedef struct packed {
    logic [1:0] vld;
    logic       rg;
    logic       rsp;
    logic [1:0] e_gnt;
    logic       e_rv;
    logic [1:0] e_oc;
    logic       e_pv;
  } vec_t;

  typedef struct packed {
    logic [IDW-1:0] ini;
    logic [AW-1:0]  adr;
    logic           we;
    logic [SW-1:0]  st;
    logic [DW-1:0]  d;
  } req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [1:0] oc1, oc2;
  logic err1, err2;
  int checks = 0;
  int errors = 0;

  vec_t tv [10];
  req_t rq [$];
  logic [IDW:0] tq [$];
  int ptr, win;
  bit m_rv, m_err, ld, egs, ev;
  logic [2*IDW+DW-1:0] m_rd;
  logic [1:0] eg;
  logic [PW-1:0] p;
  req_t r;
  logic [IDW:0] t;

  always #5 clk = ~clk;

  xt_unit_mp_if #(.AW(AW), .DW(DW), .IDW(IDW), .NI(NI)) b1 ();
  xt_unit_mp_if #(.AW(AW), .DW(DW), .IDW(IDW), .NI(NI)) b2 ();

  xt_unit_mp #(.AW(AW), .DW(DW), .IDW(IDW), .ID(0), .NI(NI), .REQ_DEPTH(RD),
    .OUTSTANDING_NUM(ON), .WR_RSP(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1), .outst_cnt(oc1), .err(err1));
  xt_unit_mp #(.AW(AW), .DW(DW), .IDW(IDW), .ID(0), .NI(NI), .REQ_DEPTH(RD),
    .OUTSTANDING_NUM(ON), .WR_RSP(0)) u2 (.clk(clk), .rstn(rstn), .bus(b2), .outst_cnt(oc2), .err(err2));

  function automatic logic [PW-1:0] mk(input logic [IDW-1:0] ini, input logic [IDW-1:0] tgt,
    input logic [AW-1:0] adr, input logic we, input logic [SW-1:0] st, input logic [DW-1:0] d);
    return {ini, tgt, adr, we, st, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    b1.tpkt_vld = '0; b1.tpkt_dat = '0; b1.req_gnt = 0; b1.rsp_vld = 0; b1.rsp_dat = '0; b1.rpkt_gnt = 1;
    b2.tpkt_vld = '0; b2.tpkt_dat = '0; b2.req_gnt = 0; b2.rsp_vld = 0; b2.rsp_dat = '0; b2.rpkt_gnt = 1;
  endtask

  task automatic do_reset;
    rstn = 0;
    idle;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle;
    do_reset;
    #4;
    chk("reset gnt", b1.tpkt_gnt, 0);
    chk("reset req_vld", b1.req_vld, 0);
    chk("reset rpkt_vld", b1.rpkt_vld, 0);
    chk("reset rpkt_dat", b1.rpkt_dat, 0);
    chk("reset outst", oc1, 0);
    chk("reset err", err1, 0);
    chk("reset rsp_gnt", b1.rsp_gnt, 1);
    nx;

    // round-robin, full FIFO without bypass, outstanding limit
    tv = '{
      '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0},
      '{2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 2'd0, 1'b0},
      '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'd0, 1'b0},
      '{2'b11, 1'b1, 1'b0, 2'b00, 1'b1, 2'd0, 1'b0},
      '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 2'd1, 1'b0},
      '{2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 2'd2, 1'b0},
      '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'd2, 1'b0},
      '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'd2, 1'b0},
      '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 2'd1, 1'b1},
      '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'd2, 1'b0}
    };
    b1.tpkt_dat = {mk(3'd6, 3'd1, 19'h123, 1'b0, 4'h3, 32'h11112222), mk(3'd4, 3'd0, 19'h55, 1'b0, 4'hF, 32'h0)};
    foreach (tv[i]) begin
      b1.tpkt_vld = tv[i].vld; b1.req_gnt = tv[i].rg; b1.rsp_vld = tv[i].rsp; b1.rsp_dat = 32'h77;
      #4;
      chk($sformatf("tab%0d gnt", i), b1.tpkt_gnt, tv[i].e_gnt);
      chk($sformatf("tab%0d req_vld", i), b1.req_vld, tv[i].e_rv);
      chk($sformatf("tab%0d outst", i), oc1, tv[i].e_oc);
      chk($sformatf("tab%0d rpkt_vld", i), b1.rpkt_vld, tv[i].e_pv);
      chk($sformatf("tab%0d rsp_gnt", i), b1.rsp_gnt, 1);
      nx;
    end
    do_reset;

    // single read from ch1
    b1.tpkt_vld = 2'b10; b1.tpkt_dat = {mk(3'd5, 3'd0, 19'h10, 1'b0, 4'hF, 32'h0), {PW{1'b0}}};
    #4; chk("rd gnt", b1.tpkt_gnt, 2'b10); chk("rd req_vld0", b1.req_vld, 0); nx;
    b1.tpkt_vld = 0; b1.req_gnt = 1;
    #4; chk("rd req_vld1", b1.req_vld, 1); chk("rd adr", b1.req_adr, 19'h10); chk("rd wr", b1.req_wr, 0); chk("rd outst0", oc1, 0); nx;
    b1.req_gnt = 0; b1.rsp_vld = 1; b1.rsp_dat = 32'hDEADBEEF;
    #4; chk("rd outst1", oc1, 1); chk("rd rsp_gnt", b1.rsp_gnt, 1); nx;
    b1.rsp_vld = 0;
    #4; chk("rd rpkt_vld", b1.rpkt_vld, 1); chk("rd rpkt_dat", b1.rpkt_dat, {3'd0, 3'd5, 32'hDEADBEEF}); chk("rd outst2", oc1, 0); nx;
    #4; chk("rd rpkt_clr", b1.rpkt_vld, 0); nx;

    // back-pressure on the response packet register
    b1.tpkt_vld = 2'b11; b1.req_gnt = 1;
    b1.tpkt_dat = {mk(3'd2, 3'd0, 19'h2, 1'b0, 4'hF, 32'h0), mk(3'd1, 3'd0, 19'h1, 1'b0, 4'hF, 32'h0)};
    #4; chk("bp gnt0", b1.tpkt_gnt, 2'b01); nx;
    #4; chk("bp gnt1", b1.tpkt_gnt, 2'b10); nx;
    b1.tpkt_vld = 0; nx;
    b1.req_gnt = 0; b1.rpkt_gnt = 0; b1.rsp_vld = 1; b1.rsp_dat = 32'hA1;
    #4; chk("bp outst", oc1, 2); chk("bp rsp_gnt0", b1.rsp_gnt, 1); nx;
    b1.rsp_dat = 32'hA2;
    #4; chk("bp rpkt1", b1.rpkt_dat, {3'd0, 3'd1, 32'hA1}); chk("bp rsp_gnt1", b1.rsp_gnt, 0); nx;
    #4; chk("bp hold", b1.rpkt_dat, {3'd0, 3'd1, 32'hA1}); chk("bp rsp_gnt2", b1.rsp_gnt, 0); chk("bp outst1", oc1, 1); nx;
    b1.rpkt_gnt = 1;
    #4; chk("bp rsp_gnt3", b1.rsp_gnt, 1); nx;
    b1.rsp_vld = 0;
    #4; chk("bp rpkt2 vld", b1.rpkt_vld, 1); chk("bp rpkt2", b1.rpkt_dat, {3'd0, 3'd2, 32'hA2}); chk("bp outst0", oc1, 0); nx;
    #4; chk("bp drained", b1.rpkt_vld, 0); nx;

    // orphan response sets sticky err; reset drops outstanding work
    b1.rsp_vld = 1; b1.rsp_dat = 32'hBAD;
    #4; chk("er rsp_gnt", b1.rsp_gnt, 1); nx;
    b1.rsp_vld = 0;
    #4; chk("er err", err1, 1); chk("er outst", oc1, 0); chk("er rpkt", b1.rpkt_vld, 0); nx;
    b1.tpkt_vld = 2'b11; b1.req_gnt = 1; nx; nx;
    b1.tpkt_vld = 0; nx;
    #4; chk("er outst2", oc1, 2); chk("er sticky", err1, 1);
    rstn = 0; b1.tpkt_vld = 2'b11; b1.rsp_vld = 1; b1.rsp_dat = 32'h99;
    #1; chk("rst gnt", b1.tpkt_gnt, 0); chk("rst req_vld", b1.req_vld, 0); chk("rst rsp_gnt", b1.rsp_gnt, 1);
    nx;
    rstn = 1; idle;
    #4; chk("rst err", err1, 0); chk("rst outst", oc1, 0); chk("rst rpkt_dat", b1.rpkt_dat, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst quiet%0d", i), {b1.rpkt_vld, b1.req_vld}, 0);
      nx;
      #4;
    end
    nx;

    // write responses dropped when WR_RSP=0
    b2.tpkt_vld = 2'b01; b2.req_gnt = 1; b2.tpkt_dat = {{PW{1'b0}}, mk(3'd2, 3'd0, 19'h5, 1'b1, 4'hF, 32'h1234)};
    #4; chk("wr gnt0", b2.tpkt_gnt, 2'b01); nx;
    b2.tpkt_dat = {{PW{1'b0}}, mk(3'd3, 3'd0, 19'h6, 1'b0, 4'hF, 32'h0)};
    #4; chk("wr gnt1", b2.tpkt_gnt, 2'b01); chk("wr is_wr", b2.req_wr, 1); nx;
    b2.tpkt_vld = 0;
    #4; chk("wr is_rd", b2.req_wr, 0); nx;
    b2.req_gnt = 0; b2.rsp_vld = 1; b2.rsp_dat = 32'hCAFE;
    #4; chk("wr outst", oc2, 2); chk("wr rsp_gnt", b2.rsp_gnt, 1); nx;
    b2.rsp_dat = 32'hF00D;
    #4; chk("wr dropped", b2.rpkt_vld, 0); chk("wr rsp_gnt2", b2.rsp_gnt, 1); nx;
    b2.rsp_vld = 0;
    #4; chk("wr rpkt", {b2.rpkt_vld, b2.rpkt_dat}, {1'b1, 3'd0, 3'd3, 32'hF00D}); chk("wr outst0", oc2, 0); nx;
    #4; chk("wr single", b2.rpkt_vld, 0); chk("wr err", err2, 0); nx;

    // random traffic against queue model
    do_reset;
    ptr = 0; m_rv = 0; m_err = 0; m_rd = '0;
    for (int c = 0; c < 400; c++) begin
      b1.tpkt_vld = 2'($urandom);
      b1.tpkt_dat = TDW'({$urandom(), $urandom(), $urandom(), $urandom()});
      b1.req_gnt = 1'($urandom);
      b1.rpkt_gnt = $urandom_range(0, 3) != 0;
      b1.rsp_vld = (tq.size() > 0) && ($urandom_range(0, 1) == 1);
      b1.rsp_dat = $urandom;
      #4;
      win = -1;
      if (rq.size() < RD)
        for (int k = 0; k < NI; k++)
          if (win < 0 && b1.tpkt_vld[(ptr + k) % NI]) win = (ptr + k) % NI;
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      ev = rq.size() > 0 && tq.size() < ON;
      egs = !m_rv || b1.rpkt_gnt;
      chk("rnd gnt", b1.tpkt_gnt, eg);
      chk("rnd req_vld", b1.req_vld, ev);
      if (ev) chk("rnd req", {b1.req_wr, b1.req_adr, b1.req_strb, b1.req_dat}, {rq[0].we, rq[0].adr, rq[0].st, rq[0].d});
      chk("rnd rsp_gnt", b1.rsp_gnt, egs);
      chk("rnd rpkt_vld", b1.rpkt_vld, m_rv);
      if (m_rv) chk("rnd rpkt_dat", b1.rpkt_dat, m_rd);
      chk("rnd outst", oc1, tq.size());
      chk("rnd err", err1, m_err);
      ld = 0;
      if (b1.rsp_vld && egs) begin
        if (tq.size() == 0) m_err = 1;
        else begin
          t = tq.pop_front();
          ld = 1;
          m_rd = {3'd0, t[IDW:1], b1.rsp_dat};
        end
      end
      m_rv = ld ? 1'b1 : (b1.rpkt_gnt ? 1'b0 : m_rv);
      if (ev && b1.req_gnt) begin
        r = rq.pop_front();
        tq.push_back({r.ini, r.we});
      end
      if (win >= 0) begin
        p = b1.tpkt_dat[win*PW +: PW];
        r = {p[PW-1 -: IDW], p[PW-2*IDW-1:0]};
        rq.push_back(r);
        ptr = (win + 1) % NI;
      end
      nx;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
